// File: rtl/vga_vram_arbiter.sv
// VRAM port arbiter: the display scan-out owns VRAM during the active region, a writer gets blanking slots.
// Optional VRAM_WR_FIFO_EN adds a 4-entry write FIFO so the writer is acknowledged at any time.
module vga_vram_arbiter #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              i_pclk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [9:0]        i_h_addr,
  input  logic [9:0]        i_v_addr,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [23:0]       i_wr_data,
  output logic              o_wr_ack,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [23:0]       o_mem_wdata,
  input  logic [23:0]       i_mem_rdata,
  output logic [23:0]       o_vga_data,
  output logic              o_busy_wr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [10:0] V_LIM = 11'(V_RES);

  logic [1:0]        r_state;
  logic              r_rng;
  logic              r_tag2;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_scan_addr;
  logic              w_pend;
  logic [ADDR_W-1:0] w_pend_addr;
  logic [23:0]       w_pend_data;

  assign w_in_range  = ({1'b0, i_h_addr} < H_LIM) && ({1'b0, i_v_addr} < V_LIM);
  assign w_scan_addr = ADDR_W'(32'(i_v_addr) * 32'(H_RES) + 32'(i_h_addr));

`ifdef VRAM_WR_FIFO_EN
  logic [ADDR_W-1:0] r_fa [4];
  logic [23:0]       r_fd [4];
  logic [1:0]        r_rd;
  logic [1:0]        r_wr;
  logic [2:0]        r_cnt;
  logic              w_drain;
  logic              w_enq;

  assign w_pend      = (r_cnt != 3'd0);
  assign w_pend_addr = r_fa[r_rd];
  assign w_pend_data = r_fd[r_rd];
  assign w_drain     = !i_valid && w_pend && !i_reset;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_enq       = i_wr_req && !i_reset && ((r_cnt != 3'd4) || w_drain);
  assign o_wr_ack    = w_enq;
  assign o_busy_wr   = i_wr_req || w_pend;

  always_ff @(posedge i_pclk) begin
    if (i_reset) begin
      r_rd  <= 2'd0;
      r_wr  <= 2'd0;
      r_cnt <= 3'd0;
    end else begin
      if (w_enq) begin
        r_fa[r_wr] <= i_wr_addr;
        r_fd[r_wr] <= i_wr_data;
        r_wr       <= r_wr + 2'd1;
      end
      if (w_drain) r_rd <= r_rd + 2'd1;
      r_cnt <= r_cnt + 3'(w_enq) - 3'(w_drain);
    end
  end
`else
  assign w_pend      = i_wr_req;
  assign w_pend_addr = i_wr_addr;
  assign w_pend_data = i_wr_data;
  assign o_wr_ack    = i_wr_req && !i_valid && !i_reset;
  assign o_busy_wr   = i_wr_req;
`endif

  // r_rng/r_state describe the slot whose address is on o_mem_addr; r_tag2 lines up with i_mem_rdata.
  always_ff @(posedge i_pclk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_rng       <= 1'b0;
      r_tag2      <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_mem_wdata <= '0;
      o_vga_data  <= '0;
    end else begin
      r_tag2     <= (r_state == S_SCAN) && r_rng;
      o_vga_data <= r_tag2 ? i_mem_rdata : 24'h0;
      r_rng      <= 1'b0;
      if (i_valid) begin
        r_state    <= S_SCAN;
        o_mem_addr <= w_scan_addr;
        o_mem_we   <= 1'b0;
        r_rng      <= w_in_range;
      end else if (w_pend) begin
        r_state     <= S_WRITE;
        o_mem_addr  <= w_pend_addr;
        o_mem_wdata <= w_pend_data;
        o_mem_we    <= 1'b1;
      end else begin
        r_state  <= S_IDLE;
        o_mem_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed self-checking bench for vga_vram_arbiter (default build; FIFO build checked when VRAM_WR_FIFO_EN is set).
module tb_vga_vram_arbiter;

  logic        clk;
  logic        reset;
  logic        valid;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_ack;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic [23:0] vga_data;
  logic        busy_wr;

  int n_tests = 0;
  int n_fail  = 0;

  vga_vram_arbiter #(.H_RES(640), .V_RES(480), .ADDR_W(19)) dut (
    .i_pclk(clk), .i_reset(reset), .i_valid(valid), .i_h_addr(h_addr), .i_v_addr(v_addr),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_vga_data(vga_data), .o_busy_wr(busy_wr)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; h_addr = '0; v_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; mem_rdata = '0;
    tick(); tick();
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check("rst_vga", 32'(vga_data), 0);
    check("rst_ack", 32'(wr_ack), 0);
    check("rst_busy", 32'(busy_wr), 0);
    reset = 1'b0;

    // single pixel (5,2): address, then read data two cycles later
    valid = 1'b1; h_addr = 10'd5; v_addr = 10'd2; mem_rdata = 24'h111111;
    tick();
    check("px_addr", 32'(mem_addr), 1285);
    check("px_we", 32'(mem_we), 0);
    valid = 1'b0; mem_rdata = 24'h222222;
    tick();
    mem_rdata = 24'hABCDEF;
    tick();
    check("px_vga", 32'(vga_data), 32'hABCDEF);
    mem_rdata = 24'h555555;
    tick();
    check("idle_vga", 32'(vga_data), 0);

    // out-of-range column
    valid = 1'b1; h_addr = 10'd640; v_addr = 10'd0;
    tick();
    check("oor_we", 32'(mem_we), 0);
    check("oor_addr", 32'(mem_addr), 640);
    valid = 1'b0; mem_rdata = 24'h666666;
    tick();
    mem_rdata = 24'h777777;
    tick();
    check("oor_vga", 32'(vga_data), 0);

    // corner addresses, truncation of the full product
    valid = 1'b1; h_addr = 10'd639; v_addr = 10'd479;
    tick();
    check("corner_addr", 32'(mem_addr), 307199);
    h_addr = 10'd1023; v_addr = 10'd1023;
    tick();
    check("trunc_addr", 32'(mem_addr), 131455);

    // streaming row 1, slot 3 out of range
    for (int k = 0; k < 6; k++) begin
      valid = 1'b1; v_addr = 10'd1;
      h_addr = (k == 3) ? 10'd700 : 10'(k);
      mem_rdata = 24'h100000 + 24'(k);
      tick();
      check("strm_addr", 32'(mem_addr), (k == 3) ? 32'd1340 : 32'(640 + k));
      if (k >= 2)
        check("strm_vga", 32'(vga_data), (k == 5) ? 32'd0 : 32'(24'h100000 + 24'(k)));
    end

`ifndef VRAM_WR_FIFO_EN
    // write held through the active region
    wr_req = 1'b1; wr_addr = 19'h100; wr_data = 24'h123456;
    for (int k = 0; k < 10; k++) begin
      valid = 1'b1; h_addr = 10'(k); v_addr = 10'd3;
      #1;
      check("act_ack", 32'(wr_ack), 0);
      tick();
      check("act_we", 32'(mem_we), 0);
      check("act_busy", 32'(busy_wr), 1);
    end
    valid = 1'b0;
    #1;
    check("blank_ack", 32'(wr_ack), 1);
    tick();
    check("blank_we", 32'(mem_we), 1);
    check("blank_addr", 32'(mem_addr), 32'h100);
    check("blank_wdata", 32'(mem_wdata), 32'h123456);
    wr_req = 1'b0;
    #1;
    check("post_ack", 32'(wr_ack), 0);
    tick();
    check("post_we", 32'(mem_we), 0);
    check("post_addr_hold", 32'(mem_addr), 32'h100);

    // display interrupts a write burst
    wr_req = 1'b1; wr_addr = 19'h1A0; wr_data = 24'hC0FFEE;
    tick();
    check("burst0_we", 32'(mem_we), 1);
    check("burst0_addr", 32'(mem_addr), 32'h1A0);
    wr_addr = 19'h1A1; valid = 1'b1; h_addr = 10'd0; v_addr = 10'd0;
    #1;
    check("burst1_ack", 32'(wr_ack), 0);
    tick();
    check("burst1_we", 32'(mem_we), 0);
    check("burst1_addr", 32'(mem_addr), 0);

    // request withdrawn before acceptance
    valid = 1'b0; wr_req = 1'b0;
    #1;
    check("drop_ack", 32'(wr_ack), 0);
    tick();
    check("drop_we", 32'(mem_we), 0);

    // reset during a write
    wr_req = 1'b1; wr_addr = 19'h200; wr_data = 24'h00AA55;
    tick();
    check("w_we", 32'(mem_we), 1);
    reset = 1'b1; wr_req = 1'b0;
    #1;
    check("rstw_ack", 32'(wr_ack), 0);
    tick();
    check("rstw_we", 32'(mem_we), 0);
    check("rstw_vga", 32'(vga_data), 0);
    check("rstw_busy", 32'(busy_wr), 0);
    reset = 1'b0;
    tick();
    check("rstw_we2", 32'(mem_we), 0);
`else
    // five writes offered during the active region
    begin
      logic [18:0] fa [5];
      int acks;
      int idx;
      fa = '{19'h10, 19'h11, 19'h12, 19'h13, 19'h14};
      acks = 0; idx = 0;
      for (int k = 0; k < 6; k++) begin
        valid = 1'b1; h_addr = 10'(k); v_addr = 10'd4;
        wr_req = 1'b1; wr_addr = fa[idx]; wr_data = 24'(idx) + 24'hF00000;
        #1;
        check("fifo_ack", 32'(wr_ack), (k < 4) ? 32'd1 : 32'd0);
        if (wr_ack) begin acks++; idx++; end
        tick();
        check("fifo_act_we", 32'(mem_we), 0);
      end
      check("fifo_acks", 32'(acks), 4);
      check("fifo_busy", 32'(busy_wr), 1);
      valid = 1'b0;
      #1;
      check("fifo_5th_ack", 32'(wr_ack), 1);
      tick();
      wr_req = 1'b0;
      for (int k = 0; k < 5; k++) begin
        check("drain_we", 32'(mem_we), 1);
        check("drain_addr", 32'(mem_addr), 32'(fa[k]));
        check("drain_data", 32'(mem_wdata), 32'(24'(k) + 24'hF00000));
        tick();
      end
      check("drain_done_we", 32'(mem_we), 0);
      check("drain_done_busy", 32'(busy_wr), 0);

      // reset mid-drain empties the FIFO
      valid = 1'b1; wr_req = 1'b1; wr_addr = 19'h30;
      tick();
      wr_addr = 19'h31;
      tick();
      wr_req = 1'b0; valid = 1'b0;
      tick();
      check("fw_we", 32'(mem_we), 1);
      reset = 1'b1;
      tick();
      check("frst_we", 32'(mem_we), 0);
      check("frst_vga", 32'(vga_data), 0);
      check("frst_busy", 32'(busy_wr), 0);
      reset = 1'b0;
      tick();
      check("frst_we2", 32'(mem_we), 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_vram_arbiter.md
VGA_VRAM_ARBITER -- requirements
Module: vga_vram_arbiter

Interface
REQ-001 Parameter H_RES, default 640, meaning active pixels per line (address stride).
REQ-002 Parameter V_RES, default 480, meaning active lines per frame.
REQ-003 Parameter ADDR_W, default 19, meaning VRAM word address width.
REQ-004 pclk  input  1  sole clock, 25 MHz pixel clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 valid  input  1  display active-region flag from the VGA timing controller.
REQ-007 h_addr  input  10  current pixel column from the timing controller.
REQ-008 v_addr  input  10  current pixel row from the timing controller.
REQ-009 wr_req  input  1  writer request; held until accepted.
REQ-010 wr_addr  input  ADDR_W  writer target word address.
REQ-011 wr_data  input  24  writer RGB word.
REQ-012 wr_ack  output  1  one-cycle pulse: current writer request accepted.
REQ-013 mem_addr  output  ADDR_W  VRAM address, registered.
REQ-014 mem_we  output  1  VRAM write enable, registered.
REQ-015 mem_wdata  output  24  VRAM write data, registered.
REQ-016 mem_rdata  input  24  VRAM read data, valid one cycle after mem_addr.
REQ-017 vga_data  output  24  RGB word to the timing controller.
REQ-018 busy_wr  output  1  high while writes are pending (request or buffered).

Function
REQ-019 FSM states: SCAN (display owns VRAM), WRITE (writer owns VRAM), IDLE (no owner).
REQ-020 valid=1 in any state: next state SCAN; mem_addr <= v_addr*H_RES + h_addr truncated to ADDR_W, mem_we <= 0.
REQ-021 valid=0 with a pending write: next state WRITE; mem_addr/mem_wdata <= pending address/data, mem_we <= 1, wr_ack pulses in that cycle (unbuffered mode).
REQ-022 valid=0 with no pending write: next state IDLE; mem_we <= 0, mem_addr holds.
REQ-023 Display always wins: a write is never issued in a cycle where valid=1, even mid-burst of writes.
REQ-024 Address multiply uses full-width product, then truncation; h_addr>=H_RES or v_addr>=V_RES while valid=1 produces mem_we=0 and vga_data=0 on that pixel.
REQ-025 vga_data registered: equals mem_rdata two cycles after a SCAN read issue (1 cycle VRAM + 1 output register); equals 0 for any pixel whose slot was WRITE or IDLE.
REQ-026 Total display latency valid/h_addr/v_addr -> vga_data = 3 pclk cycles; timing controller compensates.
REQ-027 At most one write per pclk; wr_ack never asserted in a cycle with valid=1 (unbuffered mode).
REQ-028 wr_req deassertion before acceptance drops the request with no VRAM effect.

Reset
REQ-029 reset=1 at a clock edge: state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, vga_data=0, wr_ack=0, busy_wr=0, write buffer emptied.
REQ-030 Reset mid-WRITE aborts: mem_we is 0 in the following cycle; no ack for the aborted request.

Configuration
REQ-031 Macro VRAM_WR_FIFO_EN defined: a 4-entry write FIFO sits between writer and FSM; wr_ack pulses on enqueue (any valid level) when FIFO not full; WRITE drains one entry per blanking cycle in FIFO order; busy_wr = wr_req or FIFO non-empty.
REQ-032 FIFO full: wr_ack held 0, writer stalls; simultaneous enqueue and drain on full permitted only after drain frees a slot the same cycle.
REQ-033 Macro absent: no FIFO; writer accepted only in blanking per REQ-021; busy_wr = wr_req.

Verification
REQ-034 valid=1, h_addr=5, v_addr=2 -> mem_addr=1285, mem_we=0; mem_rdata=0xABCDEF next cycle -> vga_data=0xABCDEF one cycle later.
REQ-035 wr_req with addr=0x100, data=0x123456 held during valid=1 for 10 cycles, then valid=0 -> no mem_we during active; first blank cycle mem_we=1, addr 0x100, wr_ack one pulse (macro absent).
REQ-036 Macro defined: 5 back-to-back writes during valid=1 -> 4 acks, 5th stalled; 4 writes drain in order in 4 blanking cycles, 5th accepted after first drain.
REQ-037 reset asserted during WRITE -> next cycle mem_we=0, vga_data=0, FIFO empty, busy_wr=0.
REQ-038 valid=1, h_addr=640 -> vga_data=0 for that pixel, no VRAM write.
